cmd_encoder: RTL and testbench
==============================

// Module: cmd_encoder
// PURPOSE
//  Encodes DDR3 command requests into the 2-slot-per-clk_div cmd/addr words consumed by the PHY cmd/addr serializer.
//  Each accepted command is placed in the first or second clk slot; the other slot carries a NOP.
//  A per-command wait counter enforces inter-command spacing in clk_div cycles.
//  Sits between the memory sequencer and the PHY; its outputs drive in_a/in_ba/in_we/in_ras/in_cas/in_cke/in_odt/in_tri.
// PARAMETERS
//  ADDRESS_NUMBER  15  DDR3 address width (15 for 4Gb device)
//  WAIT_WIDTH       8  width of cmd_wait / internal wait counter
// PORTS
//  clk_div     in   1                 single clock (half DDR clk rate); all logic on posedge
//  rst         in   1                 synchronous active-high reset
//  cmd_valid   in   1                 command request valid
//  cmd_ready   out  1                 encoder can accept a command this cycle
//  cmd_code    in   3                 {ras_n,cas_n,we_n}: 000 MRS,001 REF,010 PRE,011 ACT,100 WR,101 RD,110 ZQC,111 NOP
//  cmd_addr    in   ADDRESS_NUMBER    row/column/mode address
//  cmd_bank    in   3                 bank address
//  cmd_slot    in   1                 0: first clk slot, 1: second clk slot
//  cmd_wait    in   WAIT_WIDTH        clk_div cycles cmd_ready stays low after acceptance
//  cke_en      in   1                 requested CKE level
//  odt_en      in   1                 requested ODT level
//  out_en      in   1                 1: drive cmd/addr pads, 0: tristate
//  out_a       out  2*ADDRESS_NUMBER  address, bit 2i = signal i first slot, 2i+1 = second slot
//  out_ba      out  6                 bank, same slot packing
//  out_we/out_ras/out_cas  out 2 each active-low strobes, [0] first slot, [1] second slot
//  out_cke     out  2                 CKE both slots
//  out_odt     out  2                 ODT both slots
//  out_tri     out  2                 tristate both slots
//  wait_done   out  1                 one-cycle pulse when wait counter reaches 0 from nonzero
// BEHAVIOUR
//  - Reset: out_a=0, out_ba=0, out_we/ras/cas=2'b11, out_cke=2'b00, out_odt=2'b00, out_tri=2'b11,
//    counter=0, wait_done=0; cmd_ready=0 in the reset cycle.
//  - cmd_ready = ~rst & (cnt==0) & cke_r, where cke_r is cke_en registered; no commands while CKE low.
//  - Accept when cmd_valid & cmd_ready in cycle N; words appear on outputs in cycle N+1, for exactly one cycle.
//  - Issue word: selected slot strobes = cmd_code bits; other slot strobes = 1 (NOP). Address and bank
//    replicated into both slots (minimises pad toggling).
//  - Cycles without acceptance: all strobes 2'b11; out_a/out_ba hold last issued value.
//  - out_cke={2{cke_r}}, out_odt={2{odt_r}}, out_tri={2{~out_en_r}}; levels registered, 1-cycle latency, independent of handshake.
//  - Counter: on accept cnt<=cmd_wait; else if cnt!=0 cnt<=cnt-1. cmd_wait=0 allows back-to-back acceptance every cycle;
//    cmd_wait=W -> next accept earliest at N+W+1.
//  - wait_done pulses in the cycle after cnt decrements 1->0; not asserted for cmd_wait=0.
//  - cmd_code=NOP accepted normally: all strobes 1, address updated, counter loaded (timed idle).
//  - cke_en falls while cnt!=0: counter keeps counting; ready stays low until cke_r=1 again.
//  - rst mid-wait: counter cleared, pending output dropped, all outputs to reset values next cycle.
//  - cmd_valid without ready: no effect; requester must hold command stable until accepted.
// TESTING
//  1. rst=1 2 cycles -> out_we/ras/cas=11, out_cke=00, out_tri=11, cmd_ready=0; release with cke_en=1 -> ready=1 after 1 cycle.
//  2. ACT code=011, bank=5, addr=0x1234, slot=0, wait=0 -> next cycle out_ras=2'b10, out_cas=11, out_we=11,
//     out_ba=6'b110011, out_a pairs replicate 0x1234.
//  3. RD slot=1, wait=3 at cycle N -> out_cas=2'b01 at N+1; ready low N+1..N+3; wait_done at N+4; next accept at N+4.
//  4. Four WR back-to-back, wait=0 -> four consecutive issue cycles, no NOP cycle between, ready stays 1.
//  5. cke_en=0 while valid=1 -> ready=0, no strobe activity, out_cke=00 one cycle after cke_en drop.
//  6. rst asserted with cnt=5 -> next cycle counter 0, outputs at reset values; after release, accept on first ready cycle.

Source files
------------

// File: rtl/cmd_encoder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : cmd_encoder
// Description : Encodes DDR3 command requests into two-slot-per-clk_div
//               cmd/addr words for the PHY cmd/addr serializer. An accepted
//               command occupies the selected slot; the other slot is a NOP.
//               A per-command wait counter spaces commands in clk_div cycles.
// Ports       : clk_div, rst                         clock / sync reset
//               cmd_valid, cmd_ready                 request handshake
//               cmd_code/addr/bank/slot/wait         command fields
//               cke_en, odt_en, out_en               requested pad levels
//               out_a, out_ba                        slot-packed address/bank
//               out_we/ras/cas                       active-low strobes
//               out_cke, out_odt, out_tri            level outputs
//               wait_done                            wait-expired pulse
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module cmd_encoder #(
  parameter int ADDRESS_NUMBER = 15,
  parameter int WAIT_WIDTH     = 8
) (
  input  logic                        clk_div,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_code,
  input  logic [ADDRESS_NUMBER-1:0]   cmd_addr,
  input  logic [2:0]                  cmd_bank,
  input  logic                        cmd_slot,
  input  logic [WAIT_WIDTH-1:0]       cmd_wait,
  input  logic                        cke_en,
  input  logic                        odt_en,
  input  logic                        out_en,
  output logic [2*ADDRESS_NUMBER-1:0] out_a,
  output logic [5:0]                  out_ba,
  output logic [1:0]                  out_we,
  output logic [1:0]                  out_ras,
  output logic [1:0]                  out_cas,
  output logic [1:0]                  out_cke,
  output logic [1:0]                  out_odt,
  output logic [1:0]                  out_tri,
  output logic                        wait_done
);

  logic [WAIT_WIDTH-1:0]       cnt;
  logic                        cke_r;
  logic                        odt_r;
  logic                        oe_r;
  logic                        accept;
  logic [2*ADDRESS_NUMBER-1:0] a_dup;
  logic [5:0]                  ba_dup;
  logic [1:0]                  ras_w;
  logic [1:0]                  cas_w;
  logic [1:0]                  we_w;

  // No command may issue while CKE is low (self-refresh / power-down).
  assign cmd_ready = ~rst & (cnt == '0) & cke_r;
  assign accept    = cmd_valid & cmd_ready;

  // Address and bank are replicated into both slots so that the pads do not
  // toggle between the command slot and its companion NOP slot.
  generate
    for (genvar i = 0; i < ADDRESS_NUMBER; i++) begin : g_a_dup
      assign a_dup[2*i]   = cmd_addr[i];
      assign a_dup[2*i+1] = cmd_addr[i];
    end
    for (genvar j = 0; j < 3; j++) begin : g_ba_dup
      assign ba_dup[2*j]   = cmd_bank[j];
      assign ba_dup[2*j+1] = cmd_bank[j];
    end
  endgenerate

  // Selected slot takes {ras_n,cas_n,we_n}; the other slot stays NOP (all 1).
  always_comb begin
    ras_w = 2'b11;
    cas_w = 2'b11;
    we_w  = 2'b11;
    if (cmd_slot) begin
      ras_w[1] = cmd_code[2];
      cas_w[1] = cmd_code[1];
      we_w[1]  = cmd_code[0];
    end else begin
      ras_w[0] = cmd_code[2];
      cas_w[0] = cmd_code[1];
      we_w[0]  = cmd_code[0];
    end
  end

  always_ff @(posedge clk_div) begin
    if (rst) begin
      cnt       <= '0;
      cke_r     <= 1'b0;
      odt_r     <= 1'b0;
      oe_r      <= 1'b0;
      wait_done <= 1'b0;
      out_a     <= '0;
      out_ba    <= '0;
      out_ras   <= 2'b11;
      out_cas   <= 2'b11;
      out_we    <= 2'b11;
    end else begin
      cke_r     <= cke_en;
      odt_r     <= odt_en;
      oe_r      <= out_en;
      // cnt==1 can never coincide with an accept, so this marks the 1->0 step.
      wait_done <= (cnt == WAIT_WIDTH'(1));
      if (accept) begin
        cnt     <= cmd_wait;
        out_a   <= a_dup;
        out_ba  <= ba_dup;
        out_ras <= ras_w;
        out_cas <= cas_w;
        out_we  <= we_w;
      end else begin
        out_ras <= 2'b11;
        out_cas <= 2'b11;
        out_we  <= 2'b11;
        if (cnt != '0) begin
          cnt <= cnt - WAIT_WIDTH'(1);
        end
      end
    end
  end

  assign out_cke = {2{cke_r}};
  assign out_odt = {2{odt_r}};
  assign out_tri = {2{~oe_r}};

endmodule
`default_nettype wire

// File: tb/tb_cmd_encoder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_cmd_encoder
// Description : Self-checking bench for cmd_encoder. A reference model tracks
//               ready/counter/levels; issued words go through a scoreboard
//               queue and are compared one cycle after acceptance.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_cmd_encoder;

  localparam int AN = 15;
  localparam int WW = 8;

  logic          clk_div;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_code;
  logic [AN-1:0] cmd_addr;
  logic [2:0]    cmd_bank;
  logic          cmd_slot;
  logic [WW-1:0] cmd_wait;
  logic          cke_en;
  logic          odt_en;
  logic          out_en;
  logic [2*AN-1:0] out_a;
  logic [5:0]    out_ba;
  logic [1:0]    out_we;
  logic [1:0]    out_ras;
  logic [1:0]    out_cas;
  logic [1:0]    out_cke;
  logic [1:0]    out_odt;
  logic [1:0]    out_tri;
  logic          wait_done;

  cmd_encoder #(.ADDRESS_NUMBER(AN), .WAIT_WIDTH(WW)) dut (
    .clk_div  (clk_div),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_code (cmd_code),
    .cmd_addr (cmd_addr),
    .cmd_bank (cmd_bank),
    .cmd_slot (cmd_slot),
    .cmd_wait (cmd_wait),
    .cke_en   (cke_en),
    .odt_en   (odt_en),
    .out_en   (out_en),
    .out_a    (out_a),
    .out_ba   (out_ba),
    .out_we   (out_we),
    .out_ras  (out_ras),
    .out_cas  (out_cas),
    .out_cke  (out_cke),
    .out_odt  (out_odt),
    .out_tri  (out_tri),
    .wait_done(wait_done)
  );

  initial clk_div = 1'b0;
  always #5 clk_div = ~clk_div;

  typedef struct {
    logic [2*AN-1:0] a;
    logic [5:0]      ba;
    logic [1:0]      ras;
    logic [1:0]      cas;
    logic [1:0]      we;
  } word_t;

  typedef struct {
    logic [2:0]    code;
    logic [AN-1:0] addr;
    logic [2:0]    bank;
    logic          slot;
    logic [WW-1:0] wt;
    logic [1:0]    e_ras;
    logic [1:0]    e_cas;
    logic [1:0]    e_we;
    logic [5:0]    e_ba;
  } vec_t;

  word_t sbq[$];
  vec_t  tbl[8];

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [WW-1:0]   m_cnt = '0;
  logic            m_cke = 1'b0;
  logic            m_odt = 1'b0;
  logic            m_oe  = 1'b0;
  logic            m_wd  = 1'b0;
  logic [2*AN-1:0] m_a   = '0;
  logic [5:0]      m_ba  = '0;
  logic            last_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t enc(input logic [2:0] code, input logic [AN-1:0] addr,
                                input logic [2:0] bank, input logic slot);
    word_t w;
    for (int i = 0; i < AN; i++) begin
      w.a[2*i]   = addr[i];
      w.a[2*i+1] = addr[i];
    end
    for (int j = 0; j < 3; j++) begin
      w.ba[2*j]   = bank[j];
      w.ba[2*j+1] = bank[j];
    end
    w.ras = 2'b11;
    w.cas = 2'b11;
    w.we  = 2'b11;
    w.ras[slot] = code[2];
    w.cas[slot] = code[1];
    w.we[slot]  = code[0];
    return w;
  endfunction

  // One clk_div cycle: check ready, advance the model, clock, check outputs.
  task automatic tick();
    logic  m_ready;
    logic  acc;
    word_t e;
    #1;
    m_ready = !rst && (m_cnt == '0) && m_cke;
    chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_ready});
    acc = cmd_valid && m_ready;
    last_acc = acc;
    if (acc) sbq.push_back(enc(cmd_code, cmd_addr, cmd_bank, cmd_slot));
    if (rst) begin
      m_cnt = '0; m_cke = 1'b0; m_odt = 1'b0; m_oe = 1'b0; m_wd = 1'b0;
      m_a = '0; m_ba = '0;
      sbq.delete();
    end else begin
      m_wd  = (m_cnt == 8'd1);
      m_cke = cke_en;
      m_odt = odt_en;
      m_oe  = out_en;
      if (acc) m_cnt = cmd_wait;
      else if (m_cnt != '0) m_cnt = m_cnt - 8'd1;
    end
    @(posedge clk_div);
    #1;
    if (acc && sbq.size() > 0) begin
      e = sbq.pop_front();
      m_a  = e.a;
      m_ba = e.ba;
      chk("word_strobes", {26'd0, out_ras, out_cas, out_we}, {26'd0, e.ras, e.cas, e.we});
    end else begin
      chk("idle_strobes", {26'd0, out_ras, out_cas, out_we}, 32'h3f);
    end
    chk("out_a", {2'd0, out_a}, {2'd0, m_a});
    chk("out_ba", {26'd0, out_ba}, {26'd0, m_ba});
    chk("out_cke", {30'd0, out_cke}, {30'd0, {2{m_cke}}});
    chk("out_odt", {30'd0, out_odt}, {30'd0, {2{m_odt}}});
    chk("out_tri", {30'd0, out_tri}, {30'd0, {2{~m_oe}}});
    chk("wait_done", {31'd0, wait_done}, {31'd0, m_wd});
  endtask

  task automatic drive(input logic [2:0] code, input logic [AN-1:0] addr,
                       input logic [2:0] bank, input logic slot, input logic [WW-1:0] wt);
    cmd_code = code; cmd_addr = addr; cmd_bank = bank; cmd_slot = slot; cmd_wait = wt;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && !((m_cnt == '0) && m_cke); k++) tick();
    if (!((m_cnt == '0) && m_cke)) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          code    addr      bank  slot wait  ras    cas    we     ba
    tbl[0] = '{3'b011, 15'h1234, 3'd5, 1'b0, 8'd0, 2'b10, 2'b11, 2'b11, 6'b110011};
    tbl[1] = '{3'b101, 15'h0abc, 3'd2, 1'b1, 8'd3, 2'b11, 2'b01, 2'b11, 6'b001100};
    tbl[2] = '{3'b100, 15'h5555, 3'd1, 1'b0, 8'd2, 2'b11, 2'b10, 2'b10, 6'b000011};
    tbl[3] = '{3'b010, 15'h2aaa, 3'd3, 1'b1, 8'd0, 2'b01, 2'b11, 2'b01, 6'b001111};
    tbl[4] = '{3'b001, 15'h0001, 3'd4, 1'b0, 8'd1, 2'b10, 2'b10, 2'b11, 6'b110000};
    tbl[5] = '{3'b000, 15'h7fff, 3'd7, 1'b1, 8'd0, 2'b01, 2'b01, 2'b01, 6'b111111};
    tbl[6] = '{3'b110, 15'h0400, 3'd6, 1'b0, 8'd5, 2'b11, 2'b11, 2'b10, 6'b111100};
    tbl[7] = '{3'b111, 15'h3c3c, 3'd0, 1'b1, 8'd4, 2'b11, 2'b11, 2'b11, 6'b000000};

    rst = 1'b1; cmd_valid = 1'b0; cke_en = 1'b1; odt_en = 1'b0; out_en = 1'b1;
    drive(3'b111, '0, 3'd0, 1'b0, '0);

    // reset for two cycles, then release with CKE requested high
    tick();
    tick();
    chk("rst_tri", {30'd0, out_tri}, 32'd3);
    chk("rst_cke", {30'd0, out_cke}, 32'd0);
    rst = 1'b0;
    tick();
    tick();
    #1;
    chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // table-driven command encodings
    for (int i = 0; i < 8; i++) begin
      logic done;
      done = 1'b0;
      odt_en = i[0];
      out_en = ~i[1];
      drive(tbl[i].code, tbl[i].addr, tbl[i].bank, tbl[i].slot, tbl[i].wt);
      cmd_valid = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
        tick();
        done = last_acc;
      end
      cmd_valid = 1'b0;
      if (!done) chk("accept_timeout", 32'd0, 32'd1);
      else begin
        chk("tbl_ras", {30'd0, out_ras}, {30'd0, tbl[i].e_ras});
        chk("tbl_cas", {30'd0, out_cas}, {30'd0, tbl[i].e_cas});
        chk("tbl_we",  {30'd0, out_we},  {30'd0, tbl[i].e_we});
        chk("tbl_ba",  {26'd0, out_ba},  {26'd0, tbl[i].e_ba});
      end
    end
    out_en = 1'b1;
    wait_idle();

    // RD with wait=3: ready low three cycles, wait_done and next accept at N+4
    drive(3'b101, 15'h0123, 3'd1, 1'b1, 8'd3);
    cmd_valid = 1'b1;
    tick();
    chk("rd_accept", {31'd0, last_acc}, 32'd1);
    chk("rd_cas", {30'd0, out_cas}, 32'd1);
    drive(3'b011, 15'h0456, 3'd2, 1'b0, 8'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rd_wait_noacc", {31'd0, last_acc}, 32'd0);
    end
    chk("rd_wait_done", {31'd0, wait_done}, 32'd1);
    tick();
    chk("rd_next_accept", {31'd0, last_acc}, 32'd1);

    // four back-to-back WR with wait=0
    for (int k = 0; k < 4; k++) begin
      drive(3'b100, AN'(16'h0100 + k), 3'(k), k[0], 8'd0);
      tick();
      chk("wr_b2b", {31'd0, last_acc}, 32'd1);
    end
    cmd_valid = 1'b0;

    // CKE low blocks commands
    cke_en = 1'b0;
    tick();
    chk("cke_drop", {30'd0, out_cke}, 32'd0);
    cmd_valid = 1'b1;
    drive(3'b011, 15'h0777, 3'd3, 1'b0, 8'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("cke_noacc", {31'd0, last_acc}, 32'd0);
    end
    cmd_valid = 1'b0;
    cke_en = 1'b1;
    tick();
    tick();

    // reset in the middle of a wait
    drive(3'b011, 15'h0888, 3'd4, 1'b0, 8'd7);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_a", {2'd0, out_a}, 32'd0);
    rst = 1'b0;
    drive(3'b101, 15'h0999, 3'd5, 1'b1, 8'd0);
    cmd_valid = 1'b1;
    tick();
    chk("post_rst_wait_cke", {31'd0, last_acc}, 32'd0);
    tick();
    chk("post_rst_accept", {31'd0, last_acc}, 32'd1);
    cmd_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
